// File: rtl/inc_timer.sv
// rtl/inc_timer.sv - start/done up-count timer on a ripple-carry incrementer
//
// Purpose:
//   A start pulse latches target and counts from 0 up to it. In one-shot mode
//   a single-cycle done pulse follows the terminal count. With
//   INC_TIMER_AUTORELOAD_EN defined the timer instead reloads to 0 on the
//   terminal count, pulsing done every target+1 cycles until stop or rst.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   start  - launch request (ignored while running)
//   stop   - abort request (effective only while running)
//   target - terminal count, sampled on an accepted start
//   count  - current count (registered)
//   busy   - high while running
//   done   - terminal-count pulse (registered)
//
// Configuration macro: INC_TIMER_AUTORELOAD_EN (periodic mode when defined)

module inc_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] target,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [N-1:0] carry;
  logic [N-1:0] sum;

  // +1 ripple chain. The carry out of the top bit is never formed: one-shot
  // mode never counts past tgt_q, and periodic mode wants it discarded.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      sum[i] = count_q[i] ^ carry[i];
      if (i < N - 1) begin
        carry[i+1] = count_q[i] & carry[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts start directly so back-to-back runs have no idle gap
        if (start) begin
          tgt_d   = target;
          count_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // stop wins over terminal detect; count holds on abort
        if (stop) begin
          state_d = ST_IDLE;
        end else if (count_q == tgt_q) begin
`ifdef INC_TIMER_AUTORELOAD_EN
          count_d = '0;
          done_d  = 1'b1;
`else
          state_d = ST_DONE;
`endif
        end else begin
          count_d = sum;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifndef INC_TIMER_AUTORELOAD_EN
    done_d = (state_d == ST_DONE);
`endif
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_inc_timer.sv
// tb/tb_inc_timer.sv - randomized check of inc_timer (N=4 and N=8) against a timeline model

module tb_inc_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] target;
  logic [3:0] count4;
  logic [7:0] count8;
  logic       busy4, busy8, done4, done8;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model slot 0 tracks the N=4 instance, slot 1 the N=8 instance.
  bit m_run   [2];
  int m_t0    [2];
  int m_tgt   [2];
  int m_count [2];
  bit m_busy  [2];
  bit m_done  [2];

  always #5 clk = ~clk;

  inc_timer #(.N(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .target (target[3:0]),
    .count  (count4),
    .busy   (busy4),
    .done   (done4)
  );

  inc_timer #(.N(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .target (target),
    .count  (count8),
    .busy   (busy8),
    .done   (done8)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Timeline model: once a start is accepted at edge t0, elapsed = cyc - t0
  // determines everything by plain arithmetic.
  task automatic model_step(input int i, input int mask);
    int e;
    int period;
    if (rst) begin
      m_run[i] = 0; m_count[i] = 0; m_tgt[i] = 0; m_busy[i] = 0; m_done[i] = 0;
      return;
    end
    if (m_busy[i]) begin
      if (stop) begin
        m_run[i] = 0; m_busy[i] = 0; m_done[i] = 0;
        return;
      end
    end else if (start) begin
      m_run[i] = 1; m_t0[i] = cyc; m_tgt[i] = int'(target) & mask;
    end else begin
      m_run[i] = 0;
    end
    if (m_run[i]) begin
      e = cyc - m_t0[i];
      period = m_tgt[i] + 1;
`ifdef INC_TIMER_AUTORELOAD_EN
      m_count[i] = e % period;
      m_busy[i]  = 1;
      m_done[i]  = (e > 0) && (e % period == 0);
`else
      if (e <= m_tgt[i]) begin
        m_count[i] = e; m_busy[i] = 1; m_done[i] = 0;
      end else begin
        m_count[i] = m_tgt[i]; m_busy[i] = 0; m_done[i] = 1;
      end
`endif
    end else begin
      m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic step(input bit st, input bit sp, input int tg, input bit rs);
    start  = st;
    stop   = sp;
    target = tg[7:0];
    rst    = rs;
    @(posedge clk);
    cyc++;
    model_step(0, 15);
    model_step(1, 255);
    #1;
    check_eq("count4", int'(count4), m_count[0]);
    check_eq("busy4",  int'(busy4),  int'(m_busy[0]));
    check_eq("done4",  int'(done4),  int'(m_done[0]));
    check_eq("count8", int'(count8), m_count[1]);
    check_eq("busy8",  int'(busy8),  int'(m_busy[1]));
    check_eq("done8",  int'(done8),  int'(m_done[1]));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    start = 0; stop = 0; target = 0; rst = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_eq("reset_count8", int'(count8), 0);
    check_eq("reset_busy8", int'(busy8), 0);
    check_eq("reset_done8", int'(done8), 0);

    // one-shot target=5, then count holds
    step(1, 0, 5, 0);
    idle(12);
    // target=0
    step(1, 0, 0, 0);
    idle(5);
    // all-ones target (15 on N=4, 255 on N=8)
    step(1, 0, 255, 0);
    idle(262);
    // abort at count 3
    step(1, 0, 10, 0);
    idle(3);
    check_eq("abort_pre_count8", int'(count8), 3);
    step(0, 1, 0, 0);
    idle(15);
    // start during run ignored
    step(1, 0, 10, 0);
    idle(2);
    step(1, 0, 2, 0);
    idle(14);
    // start held high: back-to-back restarts
    for (int k = 0; k < 16; k++) step(1, 0, 3, 0);
    idle(5);
    // reset mid-run
    step(1, 0, 9, 0);
    idle(5);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(15);
    // stop outside run has no effect
    step(0, 1, 0, 0);
    idle(3);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)),
           ($urandom_range(0, 299) == 0));
    end
    idle(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
